axis_split_len_sched: RTL and testbench

Packet-level controller that sequences per-packet split lengths for the stream splitter. It queues split-length commands, admits exactly one input packet per command, and holds `split_len` stable for the whole packet so the downstream splitter never sees a length change mid-packet. It sits between the packet source and the splitter, and gates the stream handshake only; data passes through unregistered.

---
 rtl/axis_split_len_sched_pkg.sv | 13 +
 rtl/axis_split_len_sched_if.sv | 24 ++
 rtl/axis_split_len_sched_fifo.sv | 57 +++++
 rtl/axis_split_len_sched.sv | 152 +++++++++++++++
 tb/tb_axis_split_len_sched.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_split_len_sched_pkg.sv
// Shared types for the split-length scheduler.
// FSM encoding and default length width.
package axis_split_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PASS
    } sched_state_t;

    localparam int LSIZE_DEF = 16;

endpackage

// File: rtl/axis_split_len_sched_if.sv
// AXI-stream style bundle: data, valid, last, ready.
// The master drives the payload and the slave drives ready.
interface axis_split_len_sched_if #(
    parameter int DSIZE = 8
);
    logic [DSIZE-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_split_len_sched_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head.
// DEPTH must be a power of two so the pointers wrap naturally.
module common_fifo #(
    parameter int DEPTH = 4,
    parameter int DSIZE = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DSIZE-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [DSIZE-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Pointer and occupancy update for push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only occupied slots are ever read
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/axis_split_len_sched.sv
// Per-packet split-length sequencer: one queued command admits one packet,
// and split_len is held for the whole packet. Stream data is pass-through.
module axis_split_len_sched
    import axis_split_sched_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int LSIZE = LSIZE_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [LSIZE-1:0] cmd_len,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    axis_split_len_sched_if.slave  s,
    axis_split_len_sched_if.master m,
    output logic [LSIZE-1:0] split_len,
    output logic             busy,
    output logic             short_pkt,
    output logic             err_zero_len,
    output logic [15:0]      pkt_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    sched_state_t state_q, state_d;

    logic [LSIZE-1:0] split_len_q, split_len_d;
    logic [LSIZE-1:0] beat_q, beat_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic             short_q, short_d;
    logic             err_q, err_d;

    logic [CW-1:0]    q_count;
    logic [LSIZE-1:0] q_head;
    logic             q_empty;
    logic             cmd_hs;
    logic             push;
    logic             zero_cmd;
    logic             pop;
    logic             beat_hs;
    logic             last_hs;
    logic             has_work;
    logic [LSIZE:0]   beat_inc;
    logic             s_tready_o;
    logic             m_tvalid_o;
    logic [DSIZE-1:0] pass_data;

    assign q_empty   = (q_count == '0);
    assign cmd_ready = (q_count != FULL_CNT);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign zero_cmd  = cmd_hs && (cmd_len == '0);
    assign push      = cmd_hs && (cmd_len != '0);
    assign has_work  = !q_empty || push;

    assign beat_hs  = (state_q == PASS) && s.tvalid && m.tready;
    assign last_hs  = beat_hs && s.tlast;
    assign beat_inc = {1'b0, beat_q} + {{LSIZE{1'b0}}, 1'b1};

    common_fifo #(
        .DEPTH (DEPTH),
        .DSIZE (LSIZE)
    ) u_cmd_q (
        .clk     (clock),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (cmd_len),
        .rd_en   (pop),
        .rd_data (q_head),
        .count   (q_count)
    );

    // FSM state register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a same-cycle push counts as queued work
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (has_work) state_d = LOAD;
            LOAD:    state_d = PASS;
            PASS:    if (last_hs) state_d = has_work ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: stream gating, queue pop, busy
    always_comb begin
        s_tready_o = 1'b0;
        m_tvalid_o = 1'b0;
        pop        = 1'b0;
        busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: ;
            LOAD: pop = 1'b1;
            PASS: begin
                m_tvalid_o = s.tvalid;
                s_tready_o = m.tready;
            end
            default: ;
        endcase
    end

    // Length, beat counter, packet counter and event flags
    always_comb begin
        split_len_d = split_len_q;
        beat_d      = beat_q;
        pkt_cnt_d   = pkt_cnt_q;
        short_d     = 1'b0;
        err_d       = zero_cmd;
        if (pop) begin
            split_len_d = q_head;
            beat_d      = '0;
        end
        if (beat_hs && (beat_q != '1)) beat_d = beat_inc[LSIZE-1:0];
        if (last_hs) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            short_d   = (beat_inc < {1'b0, split_len_q});
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            split_len_q <= '0;
            beat_q      <= '0;
            pkt_cnt_q   <= '0;
            short_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            split_len_q <= split_len_d;
            beat_q      <= beat_d;
            pkt_cnt_q   <= pkt_cnt_d;
            short_q     <= short_d;
            err_q       <= err_d;
        end
    end

    assign pass_data    = s.tdata;
    assign m.tdata      = pass_data;
    assign m.tlast      = s.tlast;
    assign m.tvalid     = m_tvalid_o;
    assign s.tready     = s_tready_o;
    assign split_len    = split_len_q;
    assign short_pkt    = short_q;
    assign err_zero_len = err_q;
    assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_axis_split_len_sched.sv
// Directed bench for axis_split_len_sched.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_axis_split_len_sched;

    logic        clk;
    logic        rst_n;
    logic [15:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] split_len;
    logic        busy;
    logic        short_pkt;
    logic        err_zero_len;
    logic [15:0] pkt_cnt;

    int n_chk;
    int n_err;
    int exp_pkts;

    axis_split_len_sched_if #(.DSIZE(8)) s_if ();
    axis_split_len_sched_if #(.DSIZE(8)) m_if ();

    axis_split_len_sched #(
        .DSIZE (8),
        .LSIZE (16),
        .DEPTH (4)
    ) dut (
        .clock        (clk),
        .rst_n        (rst_n),
        .cmd_len      (cmd_len),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .s            (s_if),
        .m            (m_if),
        .split_len    (split_len),
        .busy         (busy),
        .short_pkt    (short_pkt),
        .err_zero_len (err_zero_len),
        .pkt_cnt      (pkt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] len);
        cmd_len   = len;
        cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_at_push", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // exp_wait < 0 skips the first-beat latency check
    task automatic send_pkt(input int nb, input logic [7:0] base,
                            input int exp_len, input int exp_wait,
                            input bit bp);
        int waits;
        int guard;
        waits = 0;
        for (int i = 0; i < nb; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = base + 8'(i);
            s_if.tlast  = (i == nb - 1);
            guard = 0;
            forever begin
                m_if.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                chk("m_tdata", 32'(m_if.tdata), 32'(s_if.tdata));
                chk("m_tlast", 32'(m_if.tlast), 32'(s_if.tlast));
                if (s_if.tready) break;
                if (i == 0) waits++;
                guard++;
                if (guard > 64) begin
                    chk("beat_timeout", 0, 1);
                    s_if.tvalid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            chk("split_len_beat", 32'(split_len), 32'(exp_len));
            chk("m_tvalid_beat", 32'(m_if.tvalid), 1);
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        exp_pkts++;
        if (exp_wait >= 0) chk("first_beat_wait", 32'(waits), 32'(exp_wait));
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        exp_pkts    = 0;
        rst_n       = 1'b0;
        cmd_len     = '0;
        cmd_valid   = 1'b0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_split_len", 32'(split_len), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_short", 32'(short_pkt), 0);
        chk("rst_err", 32'(err_zero_len), 0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
        chk("rst_s_tready", 32'(s_if.tready), 0);
        chk("rst_m_tvalid", 32'(m_if.tvalid), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // len 4, 6 beats: long packet, no short flag
        send_cmd(16'd4);
        send_pkt(6, 8'h10, 4, 1, 1'b0);
        #1;
        chk("p1_pkt_cnt", 32'(pkt_cnt), 1);
        chk("p1_short", 32'(short_pkt), 0);
        chk("p1_split_hold", 32'(split_len), 4);
        chk("p1_idle", 32'(busy), 0);
        @(negedge clk);

        // len 8, 3 beats: short flag pulses once
        send_cmd(16'd8);
        send_pkt(3, 8'h20, 8, 1, 1'b0);
        #1;
        chk("p2_short", 32'(short_pkt), 1);
        chk("p2_pkt_cnt", 32'(pkt_cnt), 2);
        @(negedge clk);
        #1;
        chk("p2_short_end", 32'(short_pkt), 0);
        @(negedge clk);

        // zero-length command is dropped with an error pulse
        send_cmd(16'd0);
        #1;
        chk("z_err", 32'(err_zero_len), 1);
        chk("z_busy", 32'(busy), 0);
        @(negedge clk);
        send_cmd(16'd3);
        #1;
        chk("z_err_end", 32'(err_zero_len), 0);
        @(negedge clk);
        send_pkt(3, 8'h30, 3, 0, 1'b0);
        #1;
        chk("z_short", 32'(short_pkt), 0);
        chk("z_pkt_cnt", 32'(pkt_cnt), 3);
        @(negedge clk);

        // packet waiting with no command is held off
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'hAA;
        s_if.tlast  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("nc_s_tready", 32'(s_if.tready), 0);
            chk("nc_m_tvalid", 32'(m_if.tvalid), 0);
            @(negedge clk);
        end
        send_cmd(16'd2);
        send_pkt(2, 8'hA0, 2, 1, 1'b0);
        #1;
        chk("nc_pkt_cnt", 32'(pkt_cnt), 4);
        @(negedge clk);

        // queue fill: 5 pops at once, 6/7/9/11 fill all 4 slots
        send_cmd(16'd5);
        send_cmd(16'd6);
        send_cmd(16'd7);
        send_cmd(16'd9);
        send_cmd(16'd11);
        #1;
        chk("full_cmd_ready", 32'(cmd_ready), 0);
        chk("full_busy", 32'(busy), 1);
        @(negedge clk);
        send_pkt(5, 8'h50, 5, 0, 1'b0);
        #1;
        chk("bb_bubble", 32'(s_if.tready), 0);
        chk("bb_still_full", 32'(cmd_ready), 0);
        @(negedge clk);
        #1;
        chk("bb_popped_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        send_pkt(6, 8'h60, 6, 0, 1'b0);
        send_pkt(7, 8'h70, 7, 1, 1'b0);
        send_pkt(9, 8'h90, 9, 1, 1'b0);
        send_pkt(11, 8'hB0, 11, 1, 1'b0);
        #1;
        chk("bb_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
        chk("bb_short", 32'(short_pkt), 0);
        chk("bb_idle", 32'(busy), 0);
        @(negedge clk);

        // random backpressure on the output side
        send_cmd(16'd4);
        send_pkt(4, 8'hC0, 4, -1, 1'b1);
        #1;
        chk("bp_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
        @(negedge clk);

        // reset in the middle of a packet with a command still queued
        send_cmd(16'd7);
        send_cmd(16'd5);
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_if.tdata = 8'hD0 + 8'(i);
            #1;
            chk("mr_beat", 32'(s_if.tready), 1);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_split_len", 32'(split_len), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_s_tready", 32'(s_if.tready), 0);
        chk("mr_m_tvalid", 32'(m_if.tvalid), 0);
        chk("mr_pkt_cnt", 32'(pkt_cnt), 0);
        chk("mr_cmd_ready", 32'(cmd_ready), 1);
        chk("mr_short", 32'(short_pkt), 0);
        chk("mr_err", 32'(err_zero_len), 0);
        s_if.tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_ready", 32'(cmd_ready), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
